// File: rtl/wordle_guess_scorer.sv
// wordle_guess_scorer
// Scores a latched guess against a latched target word with Wordle rules.
// Greens are resolved first (one letter per cycle), then yellows are found by
// sweeping every (guess letter i, target letter j) pair with j as the inner
// loop. A per-target "used" mask guarantees that each target letter credits at
// most one guess letter, which is what makes duplicate letters come out right.
// Score field encoding per letter: 00 grey, 01 yellow, 10 green.

module wordle_guess_scorer #(
  parameter int N_LETTERS = 5,
  parameter int LETTER_W  = 8
) (
  input  logic                            board_clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [N_LETTERS*LETTER_W-1:0]   guess_word,
  input  logic [N_LETTERS*LETTER_W-1:0]   target_word,
  output logic                            busy,
  output logic                            done,
  output logic                            result_valid,
  output logic [2*N_LETTERS-1:0]          score,
  output logic                            win
);

  localparam int IDX_W = (N_LETTERS > 1) ? $clog2(N_LETTERS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LETTERS - 1);

  localparam logic [1:0] SCORE_GREY   = 2'b00;
  localparam logic [1:0] SCORE_YELLOW = 2'b01;
  localparam logic [1:0] SCORE_GREEN  = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    GREEN,
    YELLOW,
    DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic [IDX_W-1:0]    i_idx;
  logic [IDX_W-1:0]    j_idx;
  logic [LETTER_W-1:0] guess_q  [N_LETTERS];
  logic [LETTER_W-1:0] target_q [N_LETTERS];
  logic [1:0]          score_q  [N_LETTERS];
  logic [N_LETTERS-1:0] used_q;
  logic                result_valid_q;

  logic [LETTER_W-1:0] guess_i;
  logic [LETTER_W-1:0] target_i;
  logic [LETTER_W-1:0] target_j;
  logic [1:0]          score_i;
  logic                used_j;
  logic                i_last;
  logic                j_last;
  logic                all_green;

  assign i_last = (i_idx == LAST_IDX);
  assign j_last = (j_idx == LAST_IDX);

  // State register; reset returns to IDLE immediately, discarding any partial score
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state sequencing plus the busy/done status decoded from the state
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = GREEN;
        end
      end
      GREEN: begin
        busy = 1'b1;
        if (i_last) begin
          next_state = YELLOW;
        end
      end
      YELLOW: begin
        busy = 1'b1;
        if (i_last && j_last) begin
          next_state = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Select the letters, score field and used bit addressed by the i/j counters
  always_comb begin
    guess_i  = '0;
    target_i = '0;
    target_j = '0;
    score_i  = SCORE_GREY;
    used_j   = 1'b0;
    for (int k = 0; k < N_LETTERS; k++) begin
      if (i_idx == IDX_W'(k)) begin
        guess_i  = guess_q[k];
        target_i = target_q[k];
        score_i  = score_q[k];
      end
      if (j_idx == IDX_W'(k)) begin
        target_j = target_q[k];
        used_j   = used_q[k];
      end
    end
  end

  // Scoring datapath: latch words on accept, green pass, then the i/j yellow sweep
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      i_idx          <= '0;
      j_idx          <= '0;
      used_q         <= '0;
      result_valid_q <= 1'b0;
      for (int k = 0; k < N_LETTERS; k++) begin
        guess_q[k]  <= '0;
        target_q[k] <= '0;
        score_q[k]  <= SCORE_GREY;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            i_idx          <= '0;
            j_idx          <= '0;
            used_q         <= '0;
            result_valid_q <= 1'b0;
            for (int k = 0; k < N_LETTERS; k++) begin
              guess_q[k]  <= guess_word[(N_LETTERS-1-k)*LETTER_W +: LETTER_W];
              target_q[k] <= target_word[(N_LETTERS-1-k)*LETTER_W +: LETTER_W];
              score_q[k]  <= SCORE_GREY;
            end
          end
        end
        GREEN: begin
          if (guess_i == target_i) begin
            for (int k = 0; k < N_LETTERS; k++) begin
              if (i_idx == IDX_W'(k)) begin
                score_q[k] <= SCORE_GREEN;
                used_q[k]  <= 1'b1;
              end
            end
          end
          i_idx <= i_last ? '0 : i_idx + 1'b1;
          j_idx <= '0;
        end
        YELLOW: begin
          if ((score_i == SCORE_GREY) && !used_j && (guess_i == target_j)) begin
            for (int k = 0; k < N_LETTERS; k++) begin
              if (i_idx == IDX_W'(k)) begin
                score_q[k] <= SCORE_YELLOW;
              end
              if (j_idx == IDX_W'(k)) begin
                used_q[k] <= 1'b1;
              end
            end
          end
          j_idx <= j_last ? '0 : j_idx + 1'b1;
          if (j_last) begin
            i_idx <= i_last ? '0 : i_idx + 1'b1;
          end
          if (i_last && j_last) begin
            result_valid_q <= 1'b1;
          end
        end
        default: begin
          i_idx <= '0;
          j_idx <= '0;
        end
      endcase
    end
  end

  // Pack the per-letter fields (letter 0 in the MSBs) and detect an all-green result
  always_comb begin
    score     = '0;
    all_green = 1'b1;
    for (int k = 0; k < N_LETTERS; k++) begin
      score[2*(N_LETTERS-1-k) +: 2] = score_q[k];
      if (score_q[k] != SCORE_GREEN) begin
        all_green = 1'b0;
      end
    end
  end

  assign result_valid = result_valid_q;
  assign win          = result_valid_q & all_green;

endmodule
